// File: rtl/video_pattern_gen.sv
// Video timing generator with a two-stage registered pixel pipeline and selectable test patterns.
// Optional moving-bar pattern (mode 7) is built when VIDEO_PATTERN_GEN_MOVING_BAR_EN is defined.
module video_pattern_gen #(
    parameter int   HOR_TOTAL_PIXELS       = 800,
    parameter int   HOR_ACTIVE_PIXELS      = 640,
    parameter int   HOR_FRONT_PORCH_PIXELS = 16,
    parameter int   HOR_SYNC_PIXELS        = 96,
    parameter logic HOR_SYNC_POLARITY      = 1'b0,
    parameter int   VER_TOTAL_PIXELS       = 525,
    parameter int   VER_ACTIVE_PIXELS      = 480,
    parameter int   VER_FRONT_PORCH_PIXELS = 10,
    parameter int   VER_SYNC_PIXELS        = 2,
    parameter logic VER_SYNC_POLARITY      = 1'b0,
    parameter int   COLOR_WIDTH            = 8,
    parameter int   GRAD_SHIFT             = 2
) (
    input  logic                                   clk_rgb,
    input  logic                                   rst_n,
    input  logic                                   ce,
    input  logic [3:0]                             mode,
    output logic                                   hs,
    output logic                                   vs,
    output logic                                   de,
    output logic [$clog2(HOR_ACTIVE_PIXELS)-1:0]   x,
    output logic [$clog2(VER_ACTIVE_PIXELS)-1:0]   y,
    output logic [COLOR_WIDTH-1:0]                 r,
    output logic [COLOR_WIDTH-1:0]                 g,
    output logic [COLOR_WIDTH-1:0]                 b,
    output logic                                   frame_start,
    output logic [3:0]                             mode_active
);

    localparam int HW = $clog2(HOR_TOTAL_PIXELS);
    localparam int VW = $clog2(VER_TOTAL_PIXELS);
    localparam int XW = $clog2(HOR_ACTIVE_PIXELS);
    localparam int YW = $clog2(VER_ACTIVE_PIXELS);
    localparam int BAR_W = HOR_ACTIVE_PIXELS / 8;

    localparam logic [HW-1:0] H_LAST = HW'(HOR_TOTAL_PIXELS - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(HOR_ACTIVE_PIXELS);
    localparam logic [HW-1:0] H_SS   = HW'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH_PIXELS);
    localparam logic [HW-1:0] H_SE   = HW'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH_PIXELS + HOR_SYNC_PIXELS);
    localparam logic [VW-1:0] V_LAST = VW'(VER_TOTAL_PIXELS - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(VER_ACTIVE_PIXELS);
    localparam logic [VW-1:0] V_SS   = VW'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH_PIXELS);
    localparam logic [VW-1:0] V_SE   = VW'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH_PIXELS + VER_SYNC_PIXELS);
    localparam logic [COLOR_WIDTH-1:0] FULL = '1;

    // Bar index counts the bar boundaries at or left of the pixel; the last bar takes any remainder.
    function automatic logic [2:0] bar_index(input logic [XW-1:0] px);
        logic [2:0] idx;
        idx = '0;
        for (int k = 1; k < 8; k++) begin
            if (int'(px) >= k * BAR_W) idx = idx + 3'd1;
        end
        return idx;
    endfunction

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b111;
            3'd1:    return 3'b110;
            3'd2:    return 3'b011;
            3'd3:    return 3'b010;
            3'd4:    return 3'b101;
            3'd5:    return 3'b100;
            3'd6:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [COLOR_WIDTH-1:0] sat_grad(input logic [XW-1:0] px);
        logic [XW-1:0] s;
        s = px >> GRAD_SHIFT;
        if (int'(s) > int'(FULL)) return FULL;
        return COLOR_WIDTH'(s);
    endfunction

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [3:0]    mode_sel;
    logic [3:0]    mode_nxt;

    logic          de_p0, hs_p0, vs_p0, fs_p0;
    logic [XW-1:0] x_p0;
    logic [YW-1:0] y_p0;

    logic          de_p1, hs_p1, vs_p1, fs_p1;
    logic [XW-1:0] x_p1;
    logic [YW-1:0] y_p1;
    logic [3:0]    mode_p1;
    logic [2:0]    bar_c;
    logic [COLOR_WIDTH-1:0] grad_c;
    logic [COLOR_WIDTH-1:0] r_p1, g_p1, b_p1;
    logic          on_bar;

    always_ff @(posedge clk_rgb or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (ce) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    // Stage p0: timing decode straight from the counters.
    assign fs_p0    = (h == '0) && (v == '0);
    assign de_p0    = (h < H_ACT) && (v < V_ACT);
    assign hs_p0    = (h >= H_SS && h < H_SE) ? HOR_SYNC_POLARITY : ~HOR_SYNC_POLARITY;
    assign vs_p0    = (v >= V_SS && v < V_SE) ? VER_SYNC_POLARITY : ~VER_SYNC_POLARITY;
    assign x_p0     = de_p0 ? h[XW-1:0] : '0;
    assign y_p0     = de_p0 ? v[YW-1:0] : '0;
    // The frame-boundary mode is forwarded so pixel (0,0) already uses it.
    assign mode_nxt = fs_p0 ? mode : mode_sel;

    always_ff @(posedge clk_rgb or negedge rst_n) begin
        if (!rst_n) begin
            mode_sel <= '0;
        end else if (ce) begin
            mode_sel <= mode_nxt;
        end
    end

`ifdef VIDEO_PATTERN_GEN_MOVING_BAR_EN
    logic [XW-1:0] pos;

    function automatic logic [XW-1:0] next_pos(input logic [XW-1:0] p);
        int n;
        n = int'(p) + 4;
        return (n >= HOR_ACTIVE_PIXELS) ? '0 : XW'(n);
    endfunction

    // Position advances only between two consecutive moving-bar frames; otherwise it restarts at 0.
    always_ff @(posedge clk_rgb or negedge rst_n) begin
        if (!rst_n) begin
            pos <= '0;
        end else if (ce && fs_p0) begin
            pos <= (mode_sel == 4'd7 && mode == 4'd7) ? next_pos(pos) : '0;
        end
    end

    assign on_bar = (int'(x_p1) >= int'(pos)) && (int'(x_p1) < int'(pos) + 16);
`else
    assign on_bar = 1'b0;
`endif

    // Stage p1: registered timing and coordinates.
    always_ff @(posedge clk_rgb or negedge rst_n) begin
        if (!rst_n) begin
            de_p1   <= 1'b0;
            hs_p1   <= ~HOR_SYNC_POLARITY;
            vs_p1   <= ~VER_SYNC_POLARITY;
            fs_p1   <= 1'b0;
            x_p1    <= '0;
            y_p1    <= '0;
            mode_p1 <= '0;
        end else if (ce) begin
            de_p1   <= de_p0;
            hs_p1   <= hs_p0;
            vs_p1   <= vs_p0;
            fs_p1   <= fs_p0;
            x_p1    <= x_p0;
            y_p1    <= y_p0;
            mode_p1 <= mode_nxt;
        end
    end

    assign bar_c  = bar_rgb(bar_index(x_p1));
    assign grad_c = sat_grad(x_p1);

    always_comb begin
        r_p1 = '0;
        g_p1 = '0;
        b_p1 = '0;
        if (de_p1) begin
            case (mode_p1)
                4'd1: r_p1 = FULL;
                4'd2: g_p1 = FULL;
                4'd3: b_p1 = FULL;
                4'd4: begin
                    r_p1 = {COLOR_WIDTH{bar_c[2]}};
                    g_p1 = {COLOR_WIDTH{bar_c[1]}};
                    b_p1 = {COLOR_WIDTH{bar_c[0]}};
                end
                4'd5: begin
                    if (x_p1[5] ^ y_p1[5]) begin
                        r_p1 = FULL;
                        g_p1 = FULL;
                        b_p1 = FULL;
                    end
                end
                4'd6: begin
                    r_p1 = grad_c;
                    g_p1 = grad_c;
                    b_p1 = grad_c;
                end
                4'd7: begin
                    if (on_bar) begin
                        r_p1 = FULL;
                        g_p1 = FULL;
                        b_p1 = FULL;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p2: registered outputs.
    always_ff @(posedge clk_rgb or negedge rst_n) begin
        if (!rst_n) begin
            de          <= 1'b0;
            hs          <= ~HOR_SYNC_POLARITY;
            vs          <= ~VER_SYNC_POLARITY;
            frame_start <= 1'b0;
            x           <= '0;
            y           <= '0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            mode_active <= '0;
        end else if (ce) begin
            de          <= de_p1;
            hs          <= hs_p1;
            vs          <= vs_p1;
            frame_start <= fs_p1;
            x           <= x_p1;
            y           <= y_p1;
            r           <= r_p1;
            g           <= g_p1;
            b           <= b_p1;
            mode_active <= mode_p1;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen on a reduced raster; expected pixels are queued per ce edge.
module tb_video_pattern_gen;

    localparam int HT = 70, HA = 64, HFP = 2, HSY = 3;
    localparam int VT = 36, VA = 33, VFP = 1, VSY = 1;
    localparam int XW = $clog2(HA);
    localparam int YW = $clog2(VA);
    localparam int FRAME = HT * VT;

    logic clk_rgb = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;
    logic [3:0] mode = 4'd0;
    logic hs, vs, de, frame_start;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [7:0] r, g, b;
    logic [3:0] mode_active;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic fs;
        logic [3:0] ma;
    } pix_t;

    int n_checks = 0;
    int n_fail = 0;
    pix_t exp_q[$];
    pix_t last_exp;
    int mh, mv, mpos;
    logic [3:0] msel;

    video_pattern_gen #(
        .HOR_TOTAL_PIXELS(HT), .HOR_ACTIVE_PIXELS(HA),
        .HOR_FRONT_PORCH_PIXELS(HFP), .HOR_SYNC_PIXELS(HSY), .HOR_SYNC_POLARITY(1'b0),
        .VER_TOTAL_PIXELS(VT), .VER_ACTIVE_PIXELS(VA),
        .VER_FRONT_PORCH_PIXELS(VFP), .VER_SYNC_PIXELS(VSY), .VER_SYNC_POLARITY(1'b0),
        .COLOR_WIDTH(8), .GRAD_SHIFT(2)
    ) dut (
        .clk_rgb(clk_rgb), .rst_n(rst_n), .ce(ce), .mode(mode),
        .hs(hs), .vs(vs), .de(de), .x(x), .y(y),
        .r(r), .g(g), .b(b),
        .frame_start(frame_start), .mode_active(mode_active)
    );

    always #5 clk_rgb = ~clk_rgb;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic pix_t rst_pix();
        pix_t p;
        p = '0;
        p.hs = 1'b1;
        p.vs = 1'b1;
        return p;
    endfunction

    function automatic pix_t dut_pix();
        pix_t p;
        p = {hs, vs, de, x, y, r, g, b, frame_start, mode_active};
        return p;
    endfunction

    function automatic pix_t model(input int hh, input int vv, input logic [3:0] ms, input int pos);
        pix_t p;
        int xx, yy, idx, val;
        logic [2:0] c;
        p = '0;
        p.de = (hh < HA) && (vv < VA);
        p.hs = (hh >= HA + HFP && hh < HA + HFP + HSY) ? 1'b0 : 1'b1;
        p.vs = (vv >= VA + VFP && vv < VA + VFP + VSY) ? 1'b0 : 1'b1;
        xx = p.de ? hh : 0;
        yy = p.de ? vv : 0;
        p.x = XW'(xx);
        p.y = YW'(yy);
        p.fs = (hh == 0) && (vv == 0);
        p.ma = ms;
        if (p.de) begin
            case (ms)
                4'd1: p.r = 8'hFF;
                4'd2: p.g = 8'hFF;
                4'd3: p.b = 8'hFF;
                4'd4: begin
                    idx = xx / (HA / 8);
                    if (idx > 7) idx = 7;
                    case (idx)
                        0: c = 3'b111;
                        1: c = 3'b110;
                        2: c = 3'b011;
                        3: c = 3'b010;
                        4: c = 3'b101;
                        5: c = 3'b100;
                        6: c = 3'b001;
                        default: c = 3'b000;
                    endcase
                    p.r = c[2] ? 8'hFF : 8'h00;
                    p.g = c[1] ? 8'hFF : 8'h00;
                    p.b = c[0] ? 8'hFF : 8'h00;
                end
                4'd5: if ((((xx >> 5) ^ (yy >> 5)) & 1) == 1) {p.r, p.g, p.b} = 24'hFFFFFF;
                4'd6: begin
                    val = xx >> 2;
                    if (val > 255) val = 255;
                    p.r = 8'(val);
                    p.g = 8'(val);
                    p.b = 8'(val);
                end
`ifdef VIDEO_PATTERN_GEN_MOVING_BAR_EN
                4'd7: if (xx >= pos && xx < pos + 16) {p.r, p.g, p.b} = 24'hFFFFFF;
`endif
                default: ;
            endcase
        end
        return p;
    endfunction

    task automatic model_reset();
        mh = 0;
        mv = 0;
        mpos = 0;
        msel = 4'd0;
        exp_q.delete();
        last_exp = rst_pix();
    endtask

    task automatic step(input logic ce_v, input logic [3:0] md);
        pix_t got;
        @(negedge clk_rgb);
        ce = ce_v;
        mode = md;
        @(posedge clk_rgb);
        #1;
        if (ce_v) begin
            if (mh == 0 && mv == 0) begin
`ifdef VIDEO_PATTERN_GEN_MOVING_BAR_EN
                if (msel == 4'd7 && md == 4'd7) mpos = (mpos + 4 >= HA) ? 0 : mpos + 4;
                else mpos = 0;
`endif
                msel = md;
            end
            exp_q.push_back(model(mh, mv, msel, mpos));
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            if (exp_q.size() >= 2) last_exp = exp_q.pop_front();
        end
        got = dut_pix();
        check_eq("pix", 64'(got), 64'(last_exp));
        if (ce_v && last_exp.de && last_exp.y == 0) begin
            if (last_exp.ma == 4'd4) begin
                if (last_exp.x == 0)  check_eq("bar_white_x0", {r, g, b}, 24'hFFFFFF);
                if (last_exp.x == 8)  check_eq("bar_yellow_x8", {r, g, b}, 24'hFFFF00);
                if (last_exp.x == 55) check_eq("bar_blue_x55", {r, g, b}, 24'h0000FF);
                if (last_exp.x == 63) check_eq("bar_black_x63", {r, g, b}, 24'h000000);
            end
            if (last_exp.ma == 4'd6 && last_exp.x == 63) check_eq("grad_x63", r, 8'd15);
            if (last_exp.x == 0 && last_exp.ma == 4'd3) check_eq("blue_at_fs", {frame_start, b}, 9'h1FF);
            if (last_exp.x == 0 && last_exp.ma == 4'd1) check_eq("red_at_fs", {frame_start, r}, 9'h1FF);
        end
    endtask

    // ce_mode: 0 always on, 1 alternate on/off, 2 random
    task automatic run(input int cycles, input logic [3:0] md, input int ce_mode);
        logic cv;
        for (int i = 0; i < cycles; i++) begin
            case (ce_mode)
                1:       cv = (i % 2 == 0);
                2:       cv = 1'($urandom_range(0, 1));
                default: cv = 1'b1;
            endcase
            step(cv, md);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_rgb);
        ce = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_eq("async_rst", 64'(dut_pix()), 64'(rst_pix()));
        @(negedge clk_rgb);
        ce = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk_rgb);
        check_eq("reset", 64'(dut_pix()), 64'(rst_pix()));
        rst_n = 1'b1;

        run(FRAME / 2, 4'd1, 0);
        run(FRAME, 4'd3, 0);
        run(FRAME, 4'd4, 0);
        run(FRAME, 4'd5, 0);
        run(FRAME, 4'd6, 0);
        run(FRAME, 4'd12, 0);
        run(2 * FRAME, 4'd2, 1);
        run(FRAME, 4'd4, 2);
        run(FRAME / 2, 4'd1, 0);
        do_reset();
        run(FRAME + 10, 4'd1, 0);
        run(17 * FRAME + 10, 4'd7, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
